uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Transmit-side frame sequencer for the UART TX path, clocked by the TX baud clock (one CLK cycle per serial bit).
- Accepts a parallel byte on a DATA_VALID strobe and serialises it as start, data LSB-first, optional parity, then stop bit(s).
- Drives the registered serial line TX_OUT and the BUSY flag.
- BUSY also gates the shared parity_calc block, which samples P_DATA on DATA_VALID && !BUSY and returns PAR_bit.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; must match the parity calculator width.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  TX baud clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to transmit.
- DATA_VALID  input  1  request strobe; honoured only when BUSY=0.
- PAR_EN  input  1  1 = insert parity bit; latched at acceptance.
- PAR_bit  input  1  parity bit from parity_calc; stable for the whole frame.
- TX_OUT  output  1  registered serial line; idle high.
- BUSY  output  1  registered; high from the acceptance edge to the end of the last stop bit.
- FRAME_DONE  output  1  registered one-cycle pulse when the frame completes.

Behaviour:
- Reset (async, RST=0): state=IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, shift register=0, bit counter=0, stop counter=0, latched par_en=0. These take effect immediately, including mid-frame; the partial frame is abandoned with no completion pulse.
- States: IDLE, START, DATA, PARITY, STOP. The state register names the bit currently on TX_OUT.
- IDLE: TX_OUT=1, BUSY=0. On the edge where DATA_VALID=1:
  - shreg<=P_DATA, par_en_q<=PAR_EN;
  - TX_OUT<=0, BUSY<=1, next state START.
  - parity_calc samples on the same edge, because BUSY is still 0.
- START: TX_OUT<=shreg[0], shreg shifts right, cnt<=0, next state DATA.
- DATA, when cnt<DATA_WIDTH-1: TX_OUT<=next LSB, cnt++.
- DATA, when cnt==DATA_WIDTH-1:
  - par_en_q=1: TX_OUT<=PAR_bit, next state PARITY;
  - par_en_q=0: TX_OUT<=1, stop_cnt<=0, next state STOP.
- PARITY: TX_OUT<=1, stop_cnt<=0, next state STOP.
- STOP, when stop_cnt<STOP_BITS-1: TX_OUT stays 1, stop_cnt++.
- STOP, when stop_cnt==STOP_BITS-1: next state IDLE, BUSY<=0, FRAME_DONE<=1 for exactly one cycle.
- Frame length: BUSY is high for 1+DATA_WIDTH+par_en_q+STOP_BITS cycles (10, 11 or 12 for 8-bit data).
- Latency: start bit appears on TX_OUT from the acceptance edge. Data bit i is on TX_OUT during cycle k+1+i, where k is the acceptance edge.
- DATA_VALID while BUSY=1 is ignored: no buffering, no queueing, and the frame in flight is not corrupted.
- Back-to-back frames: the edge that clears BUSY cannot accept. Minimum one IDLE cycle between frames, so an accepted request can never coincide with BUSY=1.
- P_DATA and PAR_EN changing mid-frame have no effect; both were latched at acceptance.
- Counter widths: cnt is clog2(DATA_WIDTH) bits, stop_cnt is 1 bit; neither counter wraps past its terminal value.
- FRAME_DONE is 0 in every cycle other than the completion pulse.

Test Plan:
- 0xA5, PAR_EN=1, parity_calc PAR_TYP=0 (PAR_bit=0) -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; BUSY high 11 cycles; FRAME_DONE pulses once on the cycle after the stop bit.
- 0x01, PAR_EN=1, PAR_TYP=1 (PAR_bit=0) -> 0,1,0,0,0,0,0,0,0,0,1; then 0x03 with PAR_TYP=1 -> parity slot =1.
- 0xFF, PAR_EN=0 -> 0,1,1,1,1,1,1,1,1,1; BUSY high exactly 10 cycles; no parity slot.
- STOP_BITS=2 build, 0x55, PAR_EN=1 -> 12-cycle frame ending with 1,1; FRAME_DONE pulses after the second stop bit.
- DATA_VALID held high continuously with P_DATA toggling -> first byte sent intact, one IDLE cycle, next frame carries the P_DATA value present at the new acceptance edge.
- RST pulsed low during data bit 4 -> TX_OUT=1, BUSY=0 asynchronously, no FRAME_DONE; the next request transmits a full correct frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop bit(s).
// Runs on the baud clock, so each CLK cycle is one serial bit time.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_bit,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int unsigned     CntW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DATA_WIDTH - 1);
    localparam logic            StopLast = 1'(STOP_BITS - 1);

    // The state names the bit currently being driven on TX_OUT.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CntW-1:0]       cnt_q;
    logic                  stop_cnt_q;
    logic                  par_en_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            TX_OUT     <= 1'b1;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    TX_OUT <= 1'b1;
                    if (DATA_VALID) begin
                        shreg_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        TX_OUT   <= 1'b0;
                        BUSY     <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    TX_OUT  <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                    cnt_q   <= '0;
                    state_q <= StData;
                end
                StData: begin
                    if (cnt_q != CntLast) begin
                        TX_OUT  <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CntW'(1);
                    end else if (par_en_q) begin
                        TX_OUT  <= PAR_bit;
                        state_q <= StParity;
                    end else begin
                        TX_OUT     <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= StStop;
                    end
                end
                StParity: begin
                    TX_OUT     <= 1'b1;
                    stop_cnt_q <= 1'b0;
                    state_q    <= StStop;
                end
                StStop: begin
                    TX_OUT <= 1'b1;
                    if (stop_cnt_q != StopLast) begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end else begin
                        // Completion edge is not an IDLE edge, so it never accepts a request.
                        BUSY       <= 1'b0;
                        FRAME_DONE <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    TX_OUT  <= 1'b1;
                    BUSY    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
